spinvaders_bomb_ctrl: RTL and testbench

Alien bomb controller: the downward counterpart of the player-projectile logic in the Space Invaders game core. It periodically picks a live alien, spawns one bomb under it, drops it toward the ship on each frame tick, detects a ship hit, and tracks remaining lives. It sits beside the game state machine, consuming its alien positions and row Y values, and feeds bomb position and hit/life status to the VGA renderer.

---
 rtl/spinvaders_pkg.sv | 28 ++
 rtl/spinvaders_lfsr8.sv | 24 ++
 rtl/spinvaders_bomb_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_spinvaders_bomb_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spinvaders_pkg.sv
// Shared constants, state encoding and row lookup for the Space Invaders alien-bomb logic.
package spinvaders_pkg;

  localparam int unsigned SCREEN_BOTTOM = 479;
  localparam int unsigned SHIP_Y        = 400;
  localparam logic [7:0]  LFSR_SEED     = 8'hA5;
  localparam logic [9:0]  BOMB_SPAWN_DY = 10'd10;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FALL,
    HIT,
    OVER
  } bomb_state_e;

  // Aliens 0-4 sit on the top row, 5-9 on the middle row, 10-14 on the bottom row.
  function automatic logic [9:0] row_y(input logic [3:0] idx, input logic [9:0] top_y,
                                       input logic [9:0] mid_y, input logic [9:0] bot_y);
    if (idx < 4'd5) begin
      return top_y;
    end else if (idx < 4'd10) begin
      return mid_y;
    end
    return bot_y;
  endfunction

endpackage

// File: rtl/spinvaders_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded on reset.
module spinvaders_lfsr8 (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);
  import spinvaders_pkg::*;

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/spinvaders_bomb_ctrl.sv
// Alien bomb controller: picks a live alien, drops one bomb per tick, scores ship hits and lives.
// Define BOMB_AIM_EN to make a falling bomb drift 1 px per tick toward the ship.
module spinvaders_bomb_ctrl #(
  parameter int unsigned NUM_ALIENS    = 15,
  parameter int unsigned BOMB_STEP     = 4,
  parameter int unsigned FIRE_PERIOD   = 32,
  parameter int unsigned SHIP_Y        = spinvaders_pkg::SHIP_Y,
  parameter int unsigned HIT_HALF_W    = 10,
  parameter int unsigned HIT_HALF_H    = 8,
  parameter int unsigned SCREEN_BOTTOM = spinvaders_pkg::SCREEN_BOTTOM,
  parameter int unsigned LIVES_INIT    = 3
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NUM_ALIENS-1:0]    alive,
  input  logic [NUM_ALIENS*10-1:0] alienX_bus,
  input  logic [9:0]               topY,
  input  logic [9:0]               midY,
  input  logic [9:0]               botY,
  input  logic [9:0]               shipX,
  output logic [9:0]               bombX,
  output logic [9:0]               bombY,
  output logic                     bomb_active,
  output logic                     ship_hit,
  output logic [1:0]               lives,
  output logic                     game_over
);
  import spinvaders_pkg::*;

  localparam int unsigned   TW         = $clog2(FIRE_PERIOD + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FIRE_PERIOD);
  localparam logic [10:0]   HIT_Y_LO   = 11'(SHIP_Y - HIT_HALF_H);
  localparam logic [10:0]   HIT_Y_HI   = 11'(SHIP_Y + HIT_HALF_H);
  localparam logic [10:0]   HIT_DX     = 11'(HIT_HALF_W);
  localparam logic [10:0]   Y_BOTTOM   = 11'(SCREEN_BOTTOM);
  localparam logic [10:0]   Y_STEP     = 11'(BOMB_STEP);
  localparam logic [3:0]    LAST_IDX   = 4'(NUM_ALIENS - 1);
  localparam logic [3:0]    NUM_IDX    = 4'(NUM_ALIENS);

  bomb_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    scan_q, scan_d;
  logic [9:0]    bomb_x_q, bomb_x_d;
  logic [9:0]    bomb_y_q, bomb_y_d;
  logic          active_q, active_d;
  logic          hit_q, hit_d;
  logic [1:0]    lives_q, lives_d;
  logic          over_q, over_d;

  logic [7:0]    lfsr;
  logic [3:0]    start_idx;
  logic [9:0]    sel_x;
  logic [10:0]   next_y;
  logic [10:0]   bx, sx, dx;
  logic          hit_now;
  logic          unused_lfsr;

  spinvaders_lfsr8 u_lfsr (
    .clk   (Clk),
    .reset (reset),
    .value (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:4];
  assign start_idx   = (lfsr[3:0] >= NUM_IDX) ? lfsr[3:0] - NUM_IDX : lfsr[3:0];
  assign sel_x       = alienX_bus[10*idx_q +: 10];

  // Widened to 11 bits so neither the step nor the difference can wrap.
  assign next_y  = {1'b0, bomb_y_q} + Y_STEP;
  assign bx      = {1'b0, bomb_x_q};
  assign sx      = {1'b0, shipX};
  assign dx      = (bx >= sx) ? bx - sx : sx - bx;
  assign hit_now = (dx <= HIT_DX) && (next_y >= HIT_Y_LO) && (next_y <= HIT_Y_HI);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    scan_d   = scan_q;
    bomb_x_d = bomb_x_q;
    bomb_y_d = bomb_y_q;
    active_d = active_q;
    hit_d    = 1'b0;
    lives_d  = lives_q;
    over_d   = over_q;

    unique case (state_q)
      IDLE: begin
        if (alive == '0) begin
          timer_d = TIMER_LOAD;
        end else if (tick) begin
          if (timer_q <= TW'(1)) begin
            state_d = SELECT;
            timer_d = TIMER_LOAD;
            idx_d   = start_idx;
            scan_d  = 4'd0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      SELECT: begin
        if (alive[idx_q]) begin
          bomb_x_d = sel_x;
          bomb_y_d = row_y(idx_q, topY, midY, botY) + BOMB_SPAWN_DY;
          active_d = 1'b1;
          state_d  = FALL;
        end else if (scan_q == LAST_IDX) begin
          state_d = IDLE;
          timer_d = TIMER_LOAD;
        end else begin
          idx_d  = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
          scan_d = scan_q + 4'd1;
        end
      end

      FALL: begin
        if (tick) begin
          if (hit_now) begin
            // Outputs are registered, so the pulse and life loss land together in HIT.
            state_d  = HIT;
            hit_d    = 1'b1;
            active_d = 1'b0;
            lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          end else if (next_y >= Y_BOTTOM) begin
            state_d  = IDLE;
            active_d = 1'b0;
            timer_d  = TIMER_LOAD;
          end else begin
            bomb_y_d = next_y[9:0];
`ifdef BOMB_AIM_EN
            if (bomb_x_q < shipX) begin
              bomb_x_d = bomb_x_q + 10'd1;
            end else if (bomb_x_q > shipX) begin
              bomb_x_d = bomb_x_q - 10'd1;
            end
`endif
          end
        end
      end

      HIT: begin
        if (lives_q == 2'd0) begin
          state_d = OVER;
          over_d  = 1'b1;
        end else begin
          state_d = IDLE;
          timer_d = TIMER_LOAD;
        end
      end

      OVER: begin
        over_d   = 1'b1;
        active_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        timer_d = TIMER_LOAD;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= TIMER_LOAD;
      idx_q    <= 4'd0;
      scan_q   <= 4'd0;
      bomb_x_q <= 10'd0;
      bomb_y_q <= 10'd0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      lives_q  <= 2'(LIVES_INIT);
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      lives_q  <= lives_d;
      over_q   <= over_d;
    end
  end

  assign bombX       = bomb_x_q;
  assign bombY       = bomb_y_q;
  assign bomb_active = active_q;
  assign ship_hit    = hit_q;
  assign lives       = lives_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_spinvaders_bomb_ctrl.sv
// Self-checking bench for spinvaders_bomb_ctrl: vector table, random drops, and corner sequences.
module tb_spinvaders_bomb_ctrl;

  localparam int FIRE_TICKS = 32;
  localparam int STEP       = 4;
  localparam int WIN_LO     = 392;
  localparam int WIN_HI     = 408;
  localparam int HALF_W     = 10;
  localparam int BOTTOM     = 479;

  logic         Clk = 1'b0;
  logic         reset;
  logic         tick;
  logic [14:0]  alive;
  logic [149:0] alienX_bus;
  logic [9:0]   topY, midY, botY, shipX;
  logic [9:0]   bombX, bombY;
  logic         bomb_active, ship_hit, game_over;
  logic [1:0]   lives;

  int checks = 0;
  int errors = 0;
  int m_lives;
  int alien_x [15];
  int row_val [3];

  typedef struct {
    logic [14:0] mask;
    int          ship;
    bit          exp_hit;
    int          exp_lives;
  } vec_t;

  always #5 Clk = ~Clk;

  spinvaders_bomb_ctrl dut (
    .Clk         (Clk),
    .reset       (reset),
    .tick        (tick),
    .alive       (alive),
    .alienX_bus  (alienX_bus),
    .topY        (topY),
    .midY        (midY),
    .botY        (botY),
    .shipX       (shipX),
    .bombX       (bombX),
    .bombY       (bombY),
    .bomb_active (bomb_active),
    .ship_hit    (ship_hit),
    .lives       (lives),
    .game_over   (game_over)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    tick = 1'b0;
  endtask

  function automatic int spawn_y(input int i);
    return row_val[i / 5] + 10;
  endfunction

  // Waits for the spawn after the expiry tick and checks it against the scan rule.
  task automatic wait_spawn(input logic [14:0] mask, output int found, output int lat);
    bit ok;
    int s;
    found = -1;
    lat   = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc(1);
      if (bomb_active) begin
        lat = c;
        break;
      end
    end
    check("spawn_latency", (lat >= 1 && lat <= 15) ? 1 : 0, 1);
    if (lat == 0) return;
    for (int i = 0; i < 15; i++) if (alien_x[i] == int'(bombX)) found = i;
    check("spawn_alien_alive", (found >= 0) ? int'(mask[found]) : 0, 1);
    if (found < 0) return;
    check("spawn_y", int'(bombY), spawn_y(found));
    // The scan started lat-1 slots before the chosen alien; every slot passed must be dead.
    ok = 1'b1;
    s  = ((found - (lat - 1)) % 15 + 15) % 15;
    for (int k = 0; k < lat - 1; k++) if (mask[(s + k) % 15]) ok = 1'b0;
    check("scan_order", int'(ok), 1);
  endtask

  task automatic run_drop(input logic [14:0] mask, input bit rel, input int ship_val,
                          output bit hit_seen);
    int found, lat, x, y, ny, ship, dx;
    bit done;
    hit_seen = 1'b0;
    done     = 1'b0;
    alive    = mask;
    repeat (FIRE_TICKS - 1) tick_once();
    check("no_early_spawn", int'(bomb_active), 0);
    tick_once();
    wait_spawn(mask, found, lat);
    if (found < 0) return;
    x     = alien_x[found];
    y     = spawn_y(found);
    ship  = rel ? x + ship_val : ship_val;
    shipX = 10'(ship);
    for (int t = 0; t < 200; t++) begin
      tick_once();
      ny = y + STEP;
      dx = (x > ship) ? x - ship : ship - x;
      if (dx <= HALF_W && ny >= WIN_LO && ny <= WIN_HI) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        check("hit_pulse", int'({ship_hit, bomb_active}), 2);
        check("hit_lives", int'(lives), m_lives);
        cyc(1);
        check("hit_one_cycle", int'(ship_hit), 0);
        check("game_over_state", int'(game_over), (m_lives == 0) ? 1 : 0);
        hit_seen = 1'b1;
        done     = 1'b1;
        break;
      end else if (ny >= BOTTOM) begin
        check("bottom_exit", int'({bomb_active, ship_hit}), 0);
        check("bottom_lives", int'(lives), m_lives);
        done = 1'b1;
        break;
      end
      y = ny;
`ifdef BOMB_AIM_EN
      if (x < ship) x++;
      else if (x > ship) x--;
`endif
      check("fall_step", int'({bomb_active, ship_hit, bombX, bombY}), (1 << 21) | (x << 10) | y);
    end
    check("fall_done", int'(done), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    bit   hit, any, wrap_seen;
    int   found, lat, guard;

    vecs[0] = '{mask: 15'h0200, ship: 200, exp_hit: 1'b1, exp_lives: 2};
    vecs[1] = '{mask: 15'h4000, ship: 50,  exp_hit: 1'b0, exp_lives: 2};
    vecs[2] = '{mask: 15'h0200, ship: 211, exp_hit: 1'b0, exp_lives: 2};
    vecs[3] = '{mask: 15'h0200, ship: 189, exp_hit: 1'b0, exp_lives: 2};
    vecs[4] = '{mask: 15'h0200, ship: 210, exp_hit: 1'b1, exp_lives: 1};

    row_val[0] = 40;
    row_val[1] = 80;
    row_val[2] = 120;
    topY = 10'd40;
    midY = 10'd80;
    botY = 10'd120;
    for (int i = 0; i < 15; i++) begin
      alien_x[i] = 20 * i + 20;
      alienX_bus[10*i +: 10] = 10'(alien_x[i]);
    end
    reset = 1'b1;
    tick  = 1'b0;
    alive = 15'h7FFF;
    shipX = 10'd0;
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;

    check("reset_bombX", int'(bombX), 0);
    check("reset_bombY", int'(bombY), 0);
    check("reset_active", int'(bomb_active), 0);
    check("reset_hit", int'(ship_hit), 0);
    check("reset_lives", int'(lives), 3);
    check("reset_game_over", int'(game_over), 0);
    m_lives = 3;

    // Every alien alive, ship far away: plain spawn then bottom exit.
    run_drop(15'h7FFF, 1'b1, 500, hit);

    for (int v = 0; v < 5; v++) begin
      run_drop(vecs[v].mask, 1'b0, vecs[v].ship, hit);
      check("vec_hit", int'(hit), int'(vecs[v].exp_hit));
      check("vec_lives", int'(lives), vecs[v].exp_lives);
    end

    // No live aliens: the timer expires without a spawn and reloads.
    alive = 15'h0000;
    any   = 1'b0;
    repeat (40) begin
      tick_once();
      any |= bomb_active;
    end
    check("no_alien_no_spawn", int'(any), 0);
    run_drop(15'h7FFF, 1'b1, 500, hit);

    // Random masks and ship placements.
    reset = 1'b1;
    cyc(1);
    reset   = 1'b0;
    m_lives = 3;
    for (int r = 0; r < 10 && m_lives > 0; r++) begin
      logic [14:0] mask;
      int          offs;
      mask = 15'($urandom);
      if (mask == 15'h0) mask = 15'h0001;
      offs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) - 15 : 400;
      run_drop(mask, 1'b1, offs, hit);
    end

    guard = 0;
    while (m_lives > 0 && guard < 4) begin
      run_drop(15'h7FFF, 1'b1, 0, hit);
      guard++;
    end
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    alive = 15'h7FFF;
    any   = 1'b0;
    repeat (40) begin
      tick_once();
      any |= bomb_active;
    end
    check("over_no_spawn", int'(any), 0);
    check("over_sticky", int'(game_over), 1);

    // Only the last alien alive; vary the LFSR phase until a scan starts at index 0.
    wrap_seen = 1'b0;
    for (int d = 0; d < 128 && !wrap_seen; d++) begin
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(d);
      alive = 15'h4000;
      repeat (FIRE_TICKS) tick_once();
      wait_spawn(15'h4000, found, lat);
      if (lat == 15) wrap_seen = 1'b1;
    end
    check("scan_wrap_seen", int'(wrap_seen), 1);

    // Bomb is in flight here; reset must clear it without a clock edge.
    check("pre_reset_active", int'(bomb_active), 1);
    reset = 1'b1;
    #1;
    check("async_reset_clear", int'({bomb_active, bombX, bombY}), 0);
    check("async_reset_lives", int'(lives), 3);
    @(negedge Clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
